mem_arb: RTL and testbench

- Arbitrates the single-ported SISC memory between two requesters: instruction fetch (I-port, driven during the control FSM's fetch state) and data load/store (D-port, driven during its mem state).
- Sequences each memory access through a fixed-latency wait phase.
- Returns read data with a one-cycle acknowledge.
- Sits between the control/datapath and the memory model.

---
 rtl/mem_arb.sv | 176 +++++++++++++++++
 tb/tb_mem_arb.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// -----------------------------------------------------------------------------
// mem_arb -- single-ported memory arbiter for the SISC core.
//
// Shares one memory port between the instruction-fetch requester (I-port) and
// the data load/store requester (D-port). A granted access spends LAT cycles
// in ACCESS, then one cycle in DONE with the owner's ack high. Read data is
// captured into rdata at the end of the last ACCESS cycle. Stores leave rdata
// untouched. Every output is a flop.
//
// Build option:
//   MEM_ARB_RR_EN  defined   -> round-robin between simultaneous requesters
//                  undefined -> D-port always wins over the I-port
//
// Parameters:
//   AW   address width
//   DW   data width
//   LAT  memory latency in cycles (1..15)
//
// Ports:
//   clk, rst_f             clock, asynchronous active-low reset
//   req_i, addr_i          I-port read request and address
//   req_d, we_d, addr_d,   D-port request, write enable, address and
//   wdata_d                store data
//   ack_i, ack_d           one-cycle completion strobes
//   rdata                  read data, valid while an ack is high
//   busy, gnt_d            access in progress / owner (1 = D-port)
//   mem_addr, mem_wdata,   memory-side address, write data, write strobe
//   mem_we
//   mem_rdata              memory-side read data
// -----------------------------------------------------------------------------
module mem_arb #(
    parameter int AW  = 16,
    parameter int DW  = 32,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          rst_f,
    input  logic          req_i,
    input  logic [AW-1:0] addr_i,
    input  logic          req_d,
    input  logic          we_d,
    input  logic [AW-1:0] addr_d,
    input  logic [DW-1:0] wdata_d,
    output logic          ack_i,
    output logic          ack_d,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          gnt_d,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Counter loads LAT-1 so that ACCESS spans exactly LAT cycles.
    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_t     state_r;
    logic [3:0] cnt_r;
    logic       store_r;     // current access is a D-port store
    logic       any_req_s;
    logic       win_d_s;     // D-port would win if granted this cycle

`ifdef MEM_ARB_RR_EN
    logic       last_gnt_d_r; // owner of the most recent grant

    // Round-robin winner: on a tie the port not granted last goes first.
    always_comb begin
        any_req_s = req_i | req_d;
        if (req_i && req_d) begin
            win_d_s = ~last_gnt_d_r;
        end else begin
            win_d_s = req_d;
        end
    end

    // Remember who was granted last, updated at every grant edge.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            last_gnt_d_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && any_req_s) begin
            last_gnt_d_r <= win_d_s;
        end else begin
            last_gnt_d_r <= last_gnt_d_r;
        end
    end
`else
    // Fixed priority: a pending D-port request always beats the I-port.
    always_comb begin
        any_req_s = req_i | req_d;
        if (req_d) begin
            win_d_s = 1'b1;
        end else begin
            win_d_s = 1'b0;
        end
    end
`endif

    // Access sequencer: IDLE -> ACCESS (LAT cycles) -> DONE (ack) -> IDLE.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            store_r   <= 1'b0;
            ack_i     <= 1'b0;
            ack_d     <= 1'b0;
            busy      <= 1'b0;
            gnt_d     <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {AW{1'b0}};
            mem_wdata <= {DW{1'b0}};
            rdata     <= {DW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ack_i <= 1'b0;
                    ack_d <= 1'b0;
                    if (any_req_s) begin
                        state_r  <= ST_ACCESS;
                        busy     <= 1'b1;
                        gnt_d    <= win_d_s;
                        cnt_r    <= CNT_INIT;
                        store_r  <= win_d_s & we_d;
                        mem_we   <= win_d_s & we_d;
                        mem_addr <= win_d_s ? addr_d : addr_i;
                        // Write data is only meaningful for a D-port store.
                        if (win_d_s && we_d) begin
                            mem_wdata <= wdata_d;
                        end else begin
                            mem_wdata <= mem_wdata;
                        end
                    end else begin
                        busy   <= 1'b0;
                        mem_we <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    // Write strobe lasts only for the first ACCESS cycle.
                    mem_we <= 1'b0;
                    if (cnt_r == 4'd0) begin
                        state_r <= ST_DONE;
                        ack_i   <= ~gnt_d;
                        ack_d   <= gnt_d;
                        if (!store_r) begin
                            rdata <= mem_rdata;
                        end else begin
                            rdata <= rdata;
                        end
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    ack_i   <= 1'b0;
                    ack_d   <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    ack_i   <= 1'b0;
                    ack_d   <= 1'b0;
                    busy    <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// -----------------------------------------------------------------------------
// tb_mem_arb -- self-checking bench for mem_arb.
//
// Main instance uses LAT=2; a second instance uses LAT=1. The memory is a
// combinational function of address. Expected completions (port and read
// data) are queued as requests are driven and compared when an ack appears.
// Inputs are driven 1 time unit after posedge; outputs are sampled on negedge.
// -----------------------------------------------------------------------------
module tb_mem_arb;

    typedef struct packed {
        logic        is_d;
        logic [31:0] data;
    } sb_t;

    logic        clk;
    logic        rst_f;
    logic        req_i, req_d, we_d;
    logic [15:0] addr_i, addr_d;
    logic [31:0] wdata_d;
    logic        ack_i, ack_d, busy, gnt_d, mem_we;
    logic [31:0] rdata, mem_wdata, mem_rdata;
    logic [15:0] mem_addr;
    logic [4:0]  flags_s;

    logic        req_i1, req_d1, we_d1;
    logic [15:0] addr_i1, addr_d1;
    logic [31:0] wdata_d1;
    logic        ack_i1, ack_d1, busy1, gnt_d1, mem_we1;
    logic [31:0] rdata1, mem_wdata1, mem_rdata1;
    logic [15:0] mem_addr1;
    logic [4:0]  flags1_s;

    int          checks;
    int          failures;
    sb_t         sb_q[$];
    sb_t         mon_e;
    logic [31:0] last_rd_m;
    logic        last_gnt_d_m;

    function automatic logic [31:0] exp_mem(input logic [15:0] a);
        if (a == 16'h0010) begin
            return 32'hDEADBEEF;
        end else begin
            return {a, ~a};
        end
    endfunction

    assign mem_rdata  = exp_mem(mem_addr);
    assign mem_rdata1 = exp_mem(mem_addr1) ^ 32'h0F0F0F0F;
    assign flags_s    = {ack_i, ack_d, busy, gnt_d & busy, mem_we};
    assign flags1_s   = {ack_i1, ack_d1, busy1, gnt_d1 & busy1, mem_we1};

    mem_arb #(.AW(16), .DW(32), .LAT(2)) u_dut (
        .clk(clk), .rst_f(rst_f),
        .req_i(req_i), .addr_i(addr_i),
        .req_d(req_d), .we_d(we_d), .addr_d(addr_d), .wdata_d(wdata_d),
        .ack_i(ack_i), .ack_d(ack_d), .rdata(rdata), .busy(busy), .gnt_d(gnt_d),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    mem_arb #(.AW(16), .DW(32), .LAT(1)) u_dut1 (
        .clk(clk), .rst_f(rst_f),
        .req_i(req_i1), .addr_i(addr_i1),
        .req_d(req_d1), .we_d(we_d1), .addr_d(addr_d1), .wdata_d(wdata_d1),
        .ack_i(ack_i1), .ack_d(ack_d1), .rdata(rdata1), .busy(busy1), .gnt_d(gnt_d1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_we(mem_we1),
        .mem_rdata(mem_rdata1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor for the LAT=2 instance.
    always @(negedge clk) begin
        if (rst_f && (ack_i || ack_d)) begin
            checks++;
            if (ack_i && ack_d) begin
                failures++;
                $display("FAIL sb_both_acks got ack_i=1 ack_d=1 exp only one");
            end else if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_ack got ack_i=%0b ack_d=%0b exp no ack", ack_i, ack_d);
            end else begin
                mon_e = sb_q.pop_front();
                if (ack_d !== mon_e.is_d || rdata !== mon_e.data) begin
                    failures++;
                    $display("FAIL sb_ack got ack_d=%0b rdata=%h exp ack_d=%0b rdata=%h",
                             ack_d, rdata, mon_e.is_d, mon_e.data);
                end
            end
        end
    end

    task automatic test_reset();
        #12;
        checks++;
        if ({flags_s, mem_addr, mem_wdata, rdata} !== 85'd0) begin
            failures++;
            $display("FAIL reset_outputs got flags=%b addr=%h wdata=%h rdata=%h exp all zero",
                     flags_s, mem_addr, mem_wdata, rdata);
        end
        @(negedge clk);
        rst_f = 1'b1;
    endtask

    task automatic test_fetch();
        logic [4:0] exp_f;
        @(posedge clk); #1;
        req_i = 1'b1; addr_i = 16'h0010;
        sb_q.push_back({1'b0, 32'hDEADBEEF});
        last_rd_m = 32'hDEADBEEF;
        last_gnt_d_m = 1'b0;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            case (c)
                1, 2:    exp_f = 5'b00100;
                3:       exp_f = 5'b10100;
                default: exp_f = 5'b00000;
            endcase
            checks++;
            if (flags_s !== exp_f) begin
                failures++;
                $display("FAIL fetch_flags cycle=%0d got=%b exp=%b", c, flags_s, exp_f);
            end
            if (c == 1 || c == 2) begin
                checks++;
                if (mem_addr !== 16'h0010) begin
                    failures++;
                    $display("FAIL fetch_addr cycle=%0d got=%h exp=0010", c, mem_addr);
                end
            end
            if (c == 3) begin
                @(posedge clk); #1;
                req_i = 1'b0;
            end
        end
    endtask

    task automatic test_store();
        logic [4:0] exp_f;
        @(posedge clk); #1;
        req_d = 1'b1; we_d = 1'b1; addr_d = 16'h0020; wdata_d = 32'h12345678;
        sb_q.push_back({1'b1, last_rd_m});
        last_gnt_d_m = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            case (c)
                1:       exp_f = 5'b00111;
                2:       exp_f = 5'b00110;
                3:       exp_f = 5'b01110;
                default: exp_f = 5'b00000;
            endcase
            checks++;
            if (flags_s !== exp_f) begin
                failures++;
                $display("FAIL store_flags cycle=%0d got=%b exp=%b", c, flags_s, exp_f);
            end
            if (c == 1) begin
                checks++;
                if (mem_wdata !== 32'h12345678 || mem_addr !== 16'h0020) begin
                    failures++;
                    $display("FAIL store_bus got addr=%h wdata=%h exp addr=0020 wdata=12345678",
                             mem_addr, mem_wdata);
                end
            end
            if (c == 3) begin
                @(posedge clk); #1;
                req_d = 1'b0; we_d = 1'b0;
            end
        end
    endtask

    task automatic test_held_off();
        logic [4:0] exp_f;
        @(posedge clk); #1;
        req_i = 1'b1; addr_i = 16'h0011;
        sb_q.push_back({1'b0, exp_mem(16'h0011)});
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            case (c)
                1, 2:    exp_f = 5'b00100;
                3:       exp_f = 5'b10100;
                5, 6:    exp_f = 5'b00110;
                7:       exp_f = 5'b01110;
                default: exp_f = 5'b00000;
            endcase
            checks++;
            if (flags_s !== exp_f) begin
                failures++;
                $display("FAIL held_flags cycle=%0d got=%b exp=%b", c, flags_s, exp_f);
            end
            if (c == 0) begin
                @(posedge clk); #1;
                req_d = 1'b1; we_d = 1'b0; addr_d = 16'h0030;
                sb_q.push_back({1'b1, exp_mem(16'h0030)});
            end
            if (c == 3) begin
                @(posedge clk); #1;
                req_i = 1'b0;
            end
            if (c == 7) begin
                @(posedge clk); #1;
                req_d = 1'b0;
            end
        end
        last_rd_m = exp_mem(16'h0030);
        last_gnt_d_m = 1'b1;
    endtask

    task automatic test_contention();
        logic [4:0]  exp_f;
        logic        first_d;
        logic [15:0] exp_a;
`ifdef MEM_ARB_RR_EN
        first_d = ~last_gnt_d_m;
`else
        first_d = 1'b1;
`endif
        @(posedge clk); #1;
        req_i = 1'b1; addr_i = 16'h0040;
        req_d = 1'b1; we_d = 1'b0; addr_d = 16'h0050;
        if (first_d) begin
            sb_q.push_back({1'b1, exp_mem(16'h0050)});
            sb_q.push_back({1'b0, exp_mem(16'h0040)});
        end else begin
            sb_q.push_back({1'b0, exp_mem(16'h0040)});
            sb_q.push_back({1'b1, exp_mem(16'h0050)});
        end
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            case (c)
                1, 2:    exp_f = {3'b001, first_d, 1'b0};
                3:       exp_f = {~first_d, first_d, 1'b1, first_d, 1'b0};
                5, 6:    exp_f = {3'b001, ~first_d, 1'b0};
                7:       exp_f = {first_d, ~first_d, 1'b1, ~first_d, 1'b0};
                default: exp_f = 5'b00000;
            endcase
            checks++;
            if (flags_s !== exp_f) begin
                failures++;
                $display("FAIL cont_flags cycle=%0d got=%b exp=%b", c, flags_s, exp_f);
            end
            if (c == 1 || c == 5) begin
                exp_a = ((c == 1) == first_d) ? 16'h0050 : 16'h0040;
                checks++;
                if (mem_addr !== exp_a) begin
                    failures++;
                    $display("FAIL cont_addr cycle=%0d got=%h exp=%h", c, mem_addr, exp_a);
                end
            end
            if (c == 3 || c == 7) begin
                @(posedge clk); #1;
                if ((c == 3) == first_d) begin
                    req_d = 1'b0;
                end else begin
                    req_i = 1'b0;
                end
            end
        end
        last_rd_m = first_d ? exp_mem(16'h0040) : exp_mem(16'h0050);
        last_gnt_d_m = ~first_d;
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        req_d = 1'b1; we_d = 1'b1; addr_d = 16'h0060; wdata_d = 32'hCAFEF00D;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (flags_s !== 5'b00111) begin
            failures++;
            $display("FAIL rstmid_pre got=%b exp=00111", flags_s);
        end
        #1;
        rst_f = 1'b0;
        #1;
        checks++;
        if (flags_s !== 5'b00000 || gnt_d !== 1'b0 || mem_addr !== 16'h0000) begin
            failures++;
            $display("FAIL rstmid_async got flags=%b gnt_d=%0b addr=%h exp 00000 0 0000",
                     flags_s, gnt_d, mem_addr);
        end
        req_d = 1'b0; we_d = 1'b0;
        last_rd_m = 32'd0;
        last_gnt_d_m = 1'b0;
        @(negedge clk);
        rst_f = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (flags_s !== 5'b00000 || rdata !== 32'd0) begin
                failures++;
                $display("FAIL rstmid_after cycle=%0d got flags=%b rdata=%h exp 00000 0",
                         c, flags_s, rdata);
            end
        end
    endtask

    task automatic test_lat1();
        logic [4:0]  exp_f;
        logic [31:0] exp_rd;
        exp_rd = exp_mem(16'h0005) ^ 32'h0F0F0F0F;
        @(posedge clk); #1;
        req_d1 = 1'b1; we_d1 = 1'b0; addr_d1 = 16'h0005;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            case (c)
                1:       exp_f = 5'b00110;
                2:       exp_f = 5'b01110;
                default: exp_f = 5'b00000;
            endcase
            checks++;
            if (flags1_s !== exp_f) begin
                failures++;
                $display("FAIL lat1_flags cycle=%0d got=%b exp=%b", c, flags1_s, exp_f);
            end
            if (c == 1) begin
                checks++;
                if (mem_addr1 !== 16'h0005 || mem_wdata1 !== 32'd0) begin
                    failures++;
                    $display("FAIL lat1_bus got addr=%h wdata=%h exp 0005 0", mem_addr1, mem_wdata1);
                end
            end
            if (c == 2) begin
                checks++;
                if (rdata1 !== exp_rd) begin
                    failures++;
                    $display("FAIL lat1_rdata got=%h exp=%h", rdata1, exp_rd);
                end
                @(posedge clk); #1;
                req_d1 = 1'b0;
            end
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        last_rd_m = 32'd0; last_gnt_d_m = 1'b0;
        rst_f = 1'b0;
        req_i = 1'b0; req_d = 1'b0; we_d = 1'b0;
        addr_i = 16'd0; addr_d = 16'd0; wdata_d = 32'd0;
        req_i1 = 1'b0; req_d1 = 1'b0; we_d1 = 1'b0;
        addr_i1 = 16'd0; addr_d1 = 16'd0; wdata_d1 = 32'd0;
        test_reset();
        test_fetch();
        test_store();
        test_held_off();
        test_contention();
        test_reset_mid();
        test_lat1();
        repeat (2) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got=%0d pending exp=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
